hp_fifo: RTL and testbench
==========================

Name: hp_fifo

Overview:
- Host-to-parasite Tube data FIFO: the host writes bytes, and the parasite reads them in order.
- Single-clock, behavioural (inferred) storage with first-word-fall-through output.
- Host- and parasite-side accesses are qualified by per-side cycle-enable strobes, so each bus access pushes or pops at most one byte per qualifying clock.
- Provides status flags to the Tube status registers and interrupt logic.

Parameters:
DEPTH_LOG2, 4, log2 of entry count (default 16 entries)
EMPTY_BYTE, 8'hAA, value driven on p_data when FIFO is empty

Ports:
clk  input  1  system clock; all state updates on rising edge
h_rst_b  input  1  asynchronous active-low reset
h_cken  input  1  host-side cycle enable (one clk per host bus cycle)
h_selectData  input  1  host data register selected
h_wr  input  1  host write qualifier (1 = write)
h_data  input  8  host write data
h_clear  input  1  synchronous flush request, sampled when h_cken=1
p_cken  input  1  parasite-side cycle enable
p_selectData  input  1  parasite data register selected
p_rdnw  input  1  parasite read/not-write (1 = read)
p_data  output  8  head byte, or EMPTY_BYTE when empty
p_data_available  output  1  FIFO non-empty
h_not_full  output  1  FIFO has at least one free entry
h_overflow  output  1  sticky: host write attempted while full
count  output  DEPTH_LOG2+1  number of valid entries, 0..2^DEPTH_LOG2

Behaviour:
- Reset (h_rst_b=0, asynchronous):
  - Write pointer, read pointer and count go to 0; h_overflow goes to 0.
  - Outputs: p_data=EMPTY_BYTE, p_data_available=0, h_not_full=1, count=0.
  - Storage contents are not reset.
- push_req = h_cken & h_selectData & h_wr.
- pop_req = p_cken & p_selectData & p_rdnw.
- full = (count == 2^DEPTH_LOG2); empty = (count == 0).
- Priority at each rising edge: h_clear (with h_cken) > push/pop.
- Clear:
  - Pointers and count go to 0; h_overflow goes to 0.
  - Any push_req or pop_req in the same cycle is discarded.
- Push (push_req & !full):
  - mem[wptr] <= h_data; wptr increments modulo 2^DEPTH_LOG2.
- Push while full:
  - If pop is also executing, the push executes (see simultaneous below).
  - Otherwise the byte is dropped and h_overflow <= 1. h_overflow is cleared only by reset or clear.
- Pop (pop_req & !empty):
  - rptr increments modulo 2^DEPTH_LOG2.
  - pop_req when empty is ignored and has no side effects.
- Simultaneous push and pop:
  - Not empty: both execute; count unchanged. This includes the full case: no overflow, and the slot freed by the pop accepts the push.
  - Empty: the pop is ignored, the push executes, and count becomes 1.
- count tracks the result: +1 on push only, -1 on pop only, unchanged on both or neither.
- p_data is combinational from mem[rptr] when !empty, else EMPTY_BYTE. A pushed byte is visible on p_data the cycle after the push edge (one-cycle write-to-read latency).
- p_data_available = !empty and h_not_full = !full, both derived from registered count (no combinational path from request inputs).
- Pointer wrap: count is DEPTH_LOG2+1 bits, so full and empty are unambiguous when wptr == rptr.
- Cycle-enable gating: with h_cken=0 or p_cken=0, the corresponding select/qualifier inputs have no effect, however long they are held.
- Reset asserted mid-access: the state is immediately emptied and no partial write persists in the visible state.

Test Plan:
- Reset then idle -> p_data=8'hAA, p_data_available=0, h_not_full=1, count=0, h_overflow=0.
- Push 8'h12 then 8'h34; pop twice on later cycles -> p_data shows 8'h12 one cycle after the first push, then 8'h34 after the first pop, then 8'hAA; count goes 1,2,1,0.
- Push 16 bytes 8'h00..8'h0F -> h_not_full=0, count=16. A 17th push of 8'hFF -> dropped, h_overflow=1. Pop all 16 -> sequence 00..0F exactly.
- Full FIFO plus simultaneous push 8'h55 and pop -> count stays 16, no overflow; after 15 more pops the final byte is 8'h55.
- Empty FIFO plus simultaneous push 8'h77 and pop -> count=1, p_data=8'h77 next cycle. Separately, push_req held for 5 clk with h_cken pulsed once -> exactly one entry.
- 3 entries and h_overflow=1, then h_clear with h_cken plus a concurrent push -> count=0, h_overflow=0, p_data=8'hAA. Separately, async reset asserted mid-stream -> outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/hp_fifo.sv
// Host-to-parasite Tube data FIFO: single clock, inferred storage, first-word-fall-through read port.
// Host pushes bytes on qualified host cycles; parasite pops them in order on qualified parasite cycles.
module hp_fifo #(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [7:0] EMPTY_BYTE = 8'hAA
) (
    input  logic                  clk,
    input  logic                  h_rst_b,
    input  logic                  h_cken,
    input  logic                  h_selectData,
    input  logic                  h_wr,
    input  logic [7:0]            h_data,
    input  logic                  h_clear,
    input  logic                  p_cken,
    input  logic                  p_selectData,
    input  logic                  p_rdnw,
    output logic [7:0]            p_data,
    output logic                  p_data_available,
    output logic                  h_not_full,
    output logic                  h_overflow,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overflow_q;

    logic full;
    logic empty;
    logic clear;
    logic push_req;
    logic pop_req;
    logic do_push;
    logic do_pop;
    logic overflow_set;

    // Handshake: a request is honoured only on a cycle where its side's cken is high;
    // there is no back-pressure, so status flags tell each side whether its access will land.
    assign push_req = h_cken & h_selectData & h_wr;
    assign pop_req  = p_cken & p_selectData & p_rdnw;
    assign clear    = h_cken & h_clear;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // A pop from a full FIFO frees the slot the simultaneous push lands in.
    assign do_pop       = pop_req & ~empty & ~clear;
    assign do_push      = push_req & (~full | do_pop) & ~clear;
    assign overflow_set = push_req & full & ~do_pop & ~clear;

    always_ff @(posedge clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
            if (do_push && !do_pop) count_q <= count_q + CNT_ONE;
            else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
            if (overflow_set) overflow_q <= 1'b1;
        end
    end

    // Storage is deliberately not reset; pointers alone define what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= h_data;
    end

    assign p_data           = empty ? EMPTY_BYTE : mem[rptr];
    assign p_data_available = ~empty;
    assign h_not_full       = ~full;
    assign h_overflow       = overflow_q;
    assign count            = count_q;

endmodule

// File: tb/tb_hp_fifo.sv
// Directed self-checking bench for hp_fifo: each scenario task drives stimulus and checks inline.
module tb_hp_fifo;

    logic       clk;
    logic       h_rst_b;
    logic       h_cken;
    logic       h_selectData;
    logic       h_wr;
    logic [7:0] h_data;
    logic       h_clear;
    logic       p_cken;
    logic       p_selectData;
    logic       p_rdnw;
    logic [7:0] p_data;
    logic       p_data_available;
    logic       h_not_full;
    logic       h_overflow;
    logic [4:0] count;

    int checks;
    int failures;
    logic [7:0] exp_q[$];

    hp_fifo #(.DEPTH_LOG2(4), .EMPTY_BYTE(8'hAA)) dut (
        .clk(clk), .h_rst_b(h_rst_b), .h_cken(h_cken), .h_selectData(h_selectData),
        .h_wr(h_wr), .h_data(h_data), .h_clear(h_clear), .p_cken(p_cken),
        .p_selectData(p_selectData), .p_rdnw(p_rdnw), .p_data(p_data),
        .p_data_available(p_data_available), .h_not_full(h_not_full),
        .h_overflow(h_overflow), .count(count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        h_cken = 0; h_selectData = 0; h_wr = 0; h_data = 8'h00; h_clear = 0;
        p_cken = 0; p_selectData = 0; p_rdnw = 0;
    endtask

    task automatic apply_reset();
        set_idle();
        h_rst_b = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        h_rst_b = 1;
    endtask

    // Driver: one clock of optional push/pop/clear; outputs settle #1 after the edge.
    task automatic drive(input logic push, input logic [7:0] d, input logic pop, input logic clr);
        @(negedge clk);
        h_cken = push | clr; h_selectData = push; h_wr = push; h_data = d; h_clear = clr;
        p_cken = pop; p_selectData = pop; p_rdnw = pop;
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (p_data !== 8'hAA) begin failures++; $display("FAIL reset_p_data got=%h exp=aa", p_data); end
        checks++; if (p_data_available !== 1'b0) begin failures++; $display("FAIL reset_avail got=%b exp=0", p_data_available); end
        checks++; if (h_not_full !== 1'b1) begin failures++; $display("FAIL reset_not_full got=%b exp=1", h_not_full); end
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (h_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", h_overflow); end
    endtask

    task automatic test_basic();
        drive(1, 8'h12, 0, 0);
        checks++; if (p_data !== 8'h12) begin failures++; $display("FAIL basic_first_data got=%h exp=12", p_data); end
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL basic_count1 got=%0d exp=1", count); end
        checks++; if (p_data_available !== 1'b1) begin failures++; $display("FAIL basic_avail got=%b exp=1", p_data_available); end
        drive(1, 8'h34, 0, 0);
        checks++; if (count !== 5'd2) begin failures++; $display("FAIL basic_count2 got=%0d exp=2", count); end
        checks++; if (p_data !== 8'h12) begin failures++; $display("FAIL basic_head_hold got=%h exp=12", p_data); end
        drive(0, 8'h00, 0, 0);
        drive(0, 8'h00, 1, 0);
        checks++; if (p_data !== 8'h34) begin failures++; $display("FAIL basic_second_data got=%h exp=34", p_data); end
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL basic_count_pop1 got=%0d exp=1", count); end
        drive(0, 8'h00, 1, 0);
        checks++; if (p_data !== 8'hAA) begin failures++; $display("FAIL basic_empty_data got=%h exp=aa", p_data); end
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL basic_count_pop2 got=%0d exp=0", count); end
        // Pop while empty must have no side effects.
        drive(0, 8'h00, 1, 0);
        checks++; if (count !== 5'd0 || p_data !== 8'hAA) begin failures++; $display("FAIL basic_pop_empty count=%0d data=%h exp=0/aa", count, p_data); end
    endtask

    task automatic test_fill_overflow();
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1, 8'(i), 0, 0);
            exp_q.push_back(8'(i));
        end
        checks++; if (h_not_full !== 1'b0) begin failures++; $display("FAIL fill_not_full got=%b exp=0", h_not_full); end
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL fill_count got=%0d exp=16", count); end
        drive(1, 8'hFF, 0, 0);
        checks++; if (h_overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%b exp=1", h_overflow); end
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL fill_count_after_drop got=%0d exp=16", count); end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp_b;
            exp_b = exp_q.pop_front();
            checks++; if (p_data !== exp_b) begin failures++; $display("FAIL fill_pop_data idx=%0d got=%h exp=%h", i, p_data, exp_b); end
            drive(0, 8'h00, 1, 0);
        end
        checks++; if (count !== 5'd0 || p_data !== 8'hAA) begin failures++; $display("FAIL fill_drained count=%0d data=%h exp=0/aa", count, p_data); end
        checks++; if (h_overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow_sticky got=%b exp=1", h_overflow); end
    endtask

    task automatic test_full_simul();
        drive(0, 8'h00, 0, 1);
        checks++; if (h_overflow !== 1'b0) begin failures++; $display("FAIL fullsim_clear_ovf got=%b exp=0", h_overflow); end
        for (int i = 0; i < 16; i++) drive(1, 8'(i), 0, 0);
        drive(1, 8'h55, 1, 0);
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL fullsim_count got=%0d exp=16", count); end
        checks++; if (h_overflow !== 1'b0) begin failures++; $display("FAIL fullsim_overflow got=%b exp=0", h_overflow); end
        checks++; if (p_data !== 8'h01) begin failures++; $display("FAIL fullsim_head got=%h exp=01", p_data); end
        for (int i = 0; i < 15; i++) drive(0, 8'h00, 1, 0);
        checks++; if (p_data !== 8'h55) begin failures++; $display("FAIL fullsim_last got=%h exp=55", p_data); end
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL fullsim_count_end got=%0d exp=1", count); end
        drive(0, 8'h00, 1, 0);
    endtask

    task automatic test_empty_simul_and_gating();
        drive(1, 8'h77, 1, 0);
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL emptysim_count got=%0d exp=1", count); end
        checks++; if (p_data !== 8'h77) begin failures++; $display("FAIL emptysim_data got=%h exp=77", p_data); end
        drive(0, 8'h00, 1, 0);
        // Select/qualifier held 5 clocks, h_cken high only on the third; parasite side held with p_cken low.
        @(negedge clk);
        h_selectData = 1; h_wr = 1; h_data = 8'h99; p_selectData = 1; p_rdnw = 1;
        for (int i = 0; i < 5; i++) begin
            h_cken = (i == 2);
            @(posedge clk);
            @(negedge clk);
        end
        set_idle();
        #1;
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL cken_count got=%0d exp=1", count); end
        checks++; if (p_data !== 8'h99) begin failures++; $display("FAIL cken_data got=%h exp=99", p_data); end
        drive(0, 8'h00, 1, 0);
    endtask

    task automatic test_clear();
        for (int i = 0; i < 16; i++) drive(1, 8'(8'h40 + i), 0, 0);
        drive(1, 8'hEE, 0, 0);
        for (int i = 0; i < 13; i++) drive(0, 8'h00, 1, 0);
        checks++; if (count !== 5'd3 || h_overflow !== 1'b1) begin failures++; $display("FAIL clear_pre count=%0d ovf=%b exp=3/1", count, h_overflow); end
        checks++; if (p_data !== 8'h4D) begin failures++; $display("FAIL clear_pre_head got=%h exp=4d", p_data); end
        drive(1, 8'hC3, 0, 1);
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL clear_count got=%0d exp=0", count); end
        checks++; if (h_overflow !== 1'b0) begin failures++; $display("FAIL clear_overflow got=%b exp=0", h_overflow); end
        checks++; if (p_data !== 8'hAA || p_data_available !== 1'b0) begin failures++; $display("FAIL clear_data got=%h avail=%b exp=aa/0", p_data, p_data_available); end
    endtask

    task automatic test_async_reset();
        drive(1, 8'h21, 0, 0);
        drive(1, 8'h22, 0, 0);
        @(negedge clk);
        h_cken = 1; h_selectData = 1; h_wr = 1; h_data = 8'h23;
        #2;
        h_rst_b = 0;
        #1;
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL areset_count got=%0d exp=0", count); end
        checks++; if (p_data !== 8'hAA || p_data_available !== 1'b0) begin failures++; $display("FAIL areset_data got=%h avail=%b exp=aa/0", p_data, p_data_available); end
        checks++; if (h_not_full !== 1'b1 || h_overflow !== 1'b0) begin failures++; $display("FAIL areset_flags nf=%b ovf=%b exp=1/0", h_not_full, h_overflow); end
        @(posedge clk);
        @(negedge clk);
        set_idle();
        h_rst_b = 1;
        @(posedge clk);
        #1;
        checks++; if (count !== 5'd0 || p_data !== 8'hAA) begin failures++; $display("FAIL areset_after count=%0d data=%h exp=0/aa", count, p_data); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        h_rst_b = 1;
        set_idle();
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_simul();
        test_empty_simul_and_gating();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
